// File: rtl/td4x_pkg.sv
// Opcode constants and decoded-control types shared by the TD4X core and its decoder.
package td4x_pkg;

   localparam logic [3:0] OpAddA = 4'b0000;
   localparam logic [3:0] OpAddB = 4'b0101;
   localparam logic [3:0] OpMovA = 4'b0011;
   localparam logic [3:0] OpMovB = 4'b0111;
   localparam logic [3:0] OpMovAb = 4'b0001;
   localparam logic [3:0] OpMovBa = 4'b0100;
   localparam logic [3:0] OpInA = 4'b0010;
   localparam logic [3:0] OpInB = 4'b0110;
   localparam logic [3:0] OpOutB = 4'b1001;
   localparam logic [3:0] OpOutIm = 4'b1011;
   localparam logic [3:0] OpJmp = 4'b1111;
   localparam logic [3:0] OpJnc = 4'b1110;
   localparam logic [3:0] OpJc = 4'b1010;
   localparam logic [3:0] OpHlt = 4'b1000;

   typedef enum logic [1:0] {DstNone, DstA, DstB} dst_e;
   typedef enum logic [1:0] {SrcIm, SrcA, SrcB, SrcIn} src_e;
   typedef enum logic [1:0] {JmpNone, JmpAlways, JmpNc, JmpC} jmp_e;

   typedef struct packed {
      dst_e dst;
      src_e src;
      logic alu_add;
      jmp_e jmp;
      logic jmp_take;
      logic out_ld;
      logic halt;
   } ctrl_t;

   // Unlisted opcodes decode to this: PC+1, carry cleared, nothing else written.
   localparam ctrl_t CtrlNop = '{
      dst: DstNone, src: SrcIm, alu_add: 1'b0, jmp: JmpNone,
      jmp_take: 1'b0, out_ld: 1'b0, halt: 1'b0
   };

endpackage

// File: rtl/td4x_if.sv
// Program-memory and I/O bundle between the TD4X core (master) and its environment (slave).
interface td4x_if #(
   parameter int unsigned DW = 4,
   parameter int unsigned AW = 4
);
   logic          en;
   logic [AW-1:0] instr_addr;
   logic [DW+3:0] instr_data;
   logic [DW-1:0] in_port;
   logic [DW-1:0] out_port;
   logic          carry;
   logic          halted;

   modport master (
      input  en, instr_data, in_port,
      output instr_addr, out_port, carry, halted
   );

   modport slave (
      output en, instr_data, in_port,
      input  instr_addr, out_port, carry, halted
   );
endinterface

// File: rtl/td4x_decode.sv
// Combinational opcode decoder: turns op and the registered carry into datapath controls.
module td4x_decode
   import td4x_pkg::*;
(
   input  logic [3:0] i_op,
   input  logic       i_carry,
   output ctrl_t      o_ctrl
);

   always_comb begin
      o_ctrl = CtrlNop;
      case (i_op)
         OpAddA:  begin o_ctrl.dst = DstA; o_ctrl.src = SrcA; o_ctrl.alu_add = 1'b1; end
         OpAddB:  begin o_ctrl.dst = DstB; o_ctrl.src = SrcB; o_ctrl.alu_add = 1'b1; end
         OpMovA:  begin o_ctrl.dst = DstA; o_ctrl.src = SrcIm; end
         OpMovB:  begin o_ctrl.dst = DstB; o_ctrl.src = SrcIm; end
         OpMovAb: begin o_ctrl.dst = DstA; o_ctrl.src = SrcB; end
         OpMovBa: begin o_ctrl.dst = DstB; o_ctrl.src = SrcA; end
         OpInA:   begin o_ctrl.dst = DstA; o_ctrl.src = SrcIn; end
         OpInB:   begin o_ctrl.dst = DstB; o_ctrl.src = SrcIn; end
         OpOutB:  begin o_ctrl.src = SrcB; o_ctrl.out_ld = 1'b1; end
         OpOutIm: begin o_ctrl.src = SrcIm; o_ctrl.out_ld = 1'b1; end
         OpJmp:   begin o_ctrl.jmp = JmpAlways; o_ctrl.jmp_take = 1'b1; end
         OpJnc:   begin o_ctrl.jmp = JmpNc; o_ctrl.jmp_take = ~i_carry; end
         OpJc:    begin o_ctrl.jmp = JmpC; o_ctrl.jmp_take = i_carry; end
         OpHlt:   o_ctrl.halt = 1'b1;
         default: o_ctrl = CtrlNop;
      endcase
   end

endmodule

// File: rtl/td4x_core.sv
// TD4X single-cycle core: holds PC, A, B, output port, carry and halt state plus the datapath.
module td4x_core
   import td4x_pkg::*;
#(
   parameter int unsigned DW = 4,
   parameter int unsigned AW = 4
) (
   input  logic     clk,
   input  logic     rst,
   td4x_if.master   bus
);

   logic [AW-1:0] r_pc;
   logic [DW-1:0] r_a;
   logic [DW-1:0] r_b;
   logic [DW-1:0] r_out;
   logic          r_carry;
   logic          r_halted;

   logic [3:0]    w_op;
   logic [DW-1:0] w_im;
   ctrl_t         w_ctrl;
   logic [DW-1:0] w_src;
   logic [DW:0]   w_sum;
   logic [AW-1:0] w_pc_next;
   logic          w_exec;

   assign w_op = bus.instr_data[DW+3:DW];
   assign w_im = bus.instr_data[DW-1:0];

   td4x_decode u_decode (
      .i_op    (w_op),
      .i_carry (r_carry),
      .o_ctrl  (w_ctrl)
   );

   always_comb begin
      w_src = w_im;
      case (w_ctrl.src)
         SrcA:    w_src = r_a;
         SrcB:    w_src = r_b;
         SrcIn:   w_src = bus.in_port;
         default: w_src = w_im;
      endcase
   end

   // Non-ADD moves pass the source straight through the adder with a zero addend.
   assign w_sum = {1'b0, w_src} + ({1'b0, w_im} & {(DW + 1){w_ctrl.alu_add}});

   always_comb begin
      if (w_ctrl.halt) begin
         w_pc_next = r_pc;
      end else if (w_ctrl.jmp != JmpNone && w_ctrl.jmp_take) begin
         w_pc_next = w_im[AW-1:0];
      end else begin
         w_pc_next = r_pc + AW'(1);
      end
   end

   assign w_exec = bus.en & ~r_halted;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc     <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_out    <= '0;
         r_carry  <= 1'b0;
         r_halted <= 1'b0;
      end else if (w_exec) begin
         r_pc    <= w_pc_next;
         r_carry <= w_ctrl.alu_add & w_sum[DW];
         if (w_ctrl.dst == DstA) r_a <= w_sum[DW-1:0];
         if (w_ctrl.dst == DstB) r_b <= w_sum[DW-1:0];
         if (w_ctrl.out_ld) r_out <= w_src;
         if (w_ctrl.halt) r_halted <= 1'b1;
      end
   end

   assign bus.instr_addr = r_pc;
   assign bus.out_port   = r_out;
   assign bus.carry      = r_carry;
   assign bus.halted     = r_halted;

endmodule

// File: tb/tb_td4x_core.sv
// Self-checking bench for td4x_core: directed programs plus random programs against a model.
module tb_td4x_core;

   typedef struct packed {
      int pc;
      int a;
      int b;
      int out;
      int carry;
      int halted;
   } model_t;

   logic clk;
   logic rst4;
   logic rst8;
   int   n_cmp;
   int   n_err;

   logic [7:0]  prog4 [16];
   logic [11:0] prog8 [64];
   model_t m4;
   model_t m8;

   td4x_if #(.DW(4), .AW(4)) bus4 ();
   td4x_if #(.DW(8), .AW(6)) bus8 ();

   td4x_core #(.DW(4), .AW(4)) u_dut4 (.clk(clk), .rst(rst4), .bus(bus4));
   td4x_core #(.DW(8), .AW(6)) u_dut8 (.clk(clk), .rst(rst8), .bus(bus8));

   assign bus4.instr_data = prog4[bus4.instr_addr];
   assign bus8.instr_data = prog8[bus8.instr_addr];

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   // Architectural effect of one clock edge, straight from the instruction-set rules.
   function automatic model_t model_step(input model_t s, input int dw, input int aw,
                                         input int instr, input bit en, input bit rst,
                                         input int inp);
      model_t n;
      int msk, amsk, op, im, sum;
      n = s;
      msk = (1 << dw) - 1;
      amsk = (1 << aw) - 1;
      op = (instr >> dw) & 15;
      im = instr & msk;
      if (rst) return '0;
      if (!en || s.halted != 0) return s;
      n.carry = 0;
      n.pc = (s.pc + 1) & amsk;
      case (op)
         0:  begin sum = s.a + im; n.a = sum & msk; n.carry = sum >> dw; end
         5:  begin sum = s.b + im; n.b = sum & msk; n.carry = sum >> dw; end
         3:  n.a = im;
         7:  n.b = im;
         1:  n.a = s.b;
         4:  n.b = s.a;
         2:  n.a = inp & msk;
         6:  n.b = inp & msk;
         9:  n.out = s.b;
         11: n.out = im;
         15: n.pc = im & amsk;
         14: if (s.carry == 0) n.pc = im & amsk;
         10: if (s.carry != 0) n.pc = im & amsk;
         8:  begin n.halted = 1; n.pc = s.pc; end
         default: ;
      endcase
      return n;
   endfunction

   task automatic tick4(input string tag);
      m4 = model_step(m4, 4, 4, int'(prog4[m4.pc]), bus4.en, rst4, int'(bus4.in_port));
      @(posedge clk);
      #1;
      check({tag, ".pc"}, int'(bus4.instr_addr), m4.pc);
      check({tag, ".out"}, int'(bus4.out_port), m4.out);
      check({tag, ".carry"}, int'(bus4.carry), m4.carry);
      check({tag, ".halted"}, int'(bus4.halted), m4.halted);
   endtask

   task automatic tick8(input string tag);
      m8 = model_step(m8, 8, 6, int'(prog8[m8.pc]), bus8.en, rst8, int'(bus8.in_port));
      @(posedge clk);
      #1;
      check({tag, ".pc"}, int'(bus8.instr_addr), m8.pc);
      check({tag, ".out"}, int'(bus8.out_port), m8.out);
      check({tag, ".carry"}, int'(bus8.carry), m8.carry);
      check({tag, ".halted"}, int'(bus8.halted), m8.halted);
   endtask

   task automatic exp4(input string tag, input int pc, input int out, input int c, input int h);
      check({tag, ".pc_k"}, int'(bus4.instr_addr), pc);
      check({tag, ".out_k"}, int'(bus4.out_port), out);
      check({tag, ".carry_k"}, int'(bus4.carry), c);
      check({tag, ".halted_k"}, int'(bus4.halted), h);
   endtask

   task automatic exp8(input string tag, input int pc, input int out, input int c, input int h);
      check({tag, ".pc_k"}, int'(bus8.instr_addr), pc);
      check({tag, ".out_k"}, int'(bus8.out_port), out);
      check({tag, ".carry_k"}, int'(bus8.carry), c);
      check({tag, ".halted_k"}, int'(bus8.halted), h);
   endtask

   task automatic clear4();
      for (int i = 0; i < 16; i++) prog4[i] = 8'hC0;
   endtask

   // Reset is applied with en high to show that rst wins.
   task automatic reset4();
      rst4 = 1'b1;
      bus4.en = 1'b1;
      tick4("rst4");
      rst4 = 1'b0;
   endtask

   initial begin
      clk = 1'b0;
      n_cmp = 0;
      n_err = 0;
      m4 = '0;
      m8 = '0;
      rst4 = 1'b1;
      rst8 = 1'b1;
      bus4.en = 1'b0;
      bus4.in_port = '0;
      bus8.en = 1'b0;
      bus8.in_port = '0;
      clear4();
      for (int i = 0; i < 64; i++) prog8[i] = 12'hC00;

      tick4("init");
      exp4("reset", 0, 0, 0, 0);

      // MOV A,F; ADD A,1 -> carry; JC 5 taken and clears carry.
      clear4();
      prog4[0] = 8'h3F; prog4[1] = 8'h01; prog4[2] = 8'hA5; prog4[5] = 8'h80;
      reset4();
      tick4("c030a");
      tick4("c030b");
      exp4("c030_add", 2, 0, 1, 0);
      tick4("c030c");
      exp4("c030_jc", 5, 0, 0, 0);

      // JNC loops on itself; fall-through would land on HLT at 3.
      clear4();
      prog4[0] = 8'h33; prog4[1] = 8'h01; prog4[2] = 8'hE2; prog4[3] = 8'h80;
      reset4();
      tick4("c031a");
      tick4("c031b");
      exp4("c031_add", 2, 0, 0, 0);
      tick4("c031c");
      exp4("c031_jnc1", 2, 0, 0, 0);
      tick4("c031d");
      exp4("c031_jnc2", 2, 0, 0, 0);

      // OUT B / OUT im / MOV A,B leaves out_port alone.
      clear4();
      prog4[0] = 8'h7A; prog4[1] = 8'h90; prog4[2] = 8'hB3; prog4[3] = 8'h10;
      prog4[4] = 8'h80;
      reset4();
      tick4("c032a");
      tick4("c032b");
      exp4("c032_outb", 2, 'hA, 0, 0);
      tick4("c032c");
      exp4("c032_outim", 3, 3, 0, 0);
      tick4("c032d");
      exp4("c032_movab", 4, 3, 0, 0);

      // IN A; MOV B,A; OUT B with gated edges in between.
      clear4();
      prog4[0] = 8'h20; prog4[1] = 8'h40; prog4[2] = 8'h90;
      reset4();
      bus4.in_port = 4'h6;
      tick4("c033a");
      bus4.en = 1'b0;
      bus4.in_port = 4'h9;
      tick4("c033g1");
      tick4("c033g2");
      exp4("c033_gate1", 1, 0, 0, 0);
      bus4.en = 1'b1;
      tick4("c033b");
      bus4.en = 1'b0;
      tick4("c033g3");
      exp4("c033_gate2", 2, 0, 0, 0);
      bus4.en = 1'b1;
      tick4("c033c");
      exp4("c033_out", 3, 6, 0, 0);

      // HLT at 7 just after a carry-setting ADD; then held, then reset.
      clear4();
      prog4[0] = 8'h3F; prog4[1] = 8'h01; prog4[2] = 8'hC5; prog4[3] = 8'hB7;
      prog4[4] = 8'hD0; prog4[5] = 8'h3F; prog4[6] = 8'h01; prog4[7] = 8'h80;
      reset4();
      for (int i = 0; i < 8; i++) tick4("c034run");
      exp4("c034_halt", 7, 7, 0, 1);
      for (int i = 0; i < 10; i++) begin
         bus4.en = 1'($urandom_range(0, 1));
         bus4.in_port = 4'($urandom);
         tick4("c034hold");
      end
      exp4("c034_held", 7, 7, 0, 1);
      rst4 = 1'b1;
      tick4("c034rst");
      exp4("c034_reset", 0, 0, 0, 0);
      rst4 = 1'b0;

      // Wide core: 8-bit ADD carry, JMP target truncated to 6 bits, PC wrap at 0x3F.
      rst4 = 1'b1;
      bus8.en = 1'b1;
      prog8[0] = 12'h301; prog8[1] = 12'h0FF; prog8[2] = 12'hFC5; prog8[5] = 12'hF3F;
      prog8[63] = 12'hC00;
      tick8("c035rst");
      rst8 = 1'b0;
      tick8("c035a");
      tick8("c035b");
      exp8("c035_add", 2, 0, 1, 0);
      tick8("c035c");
      exp8("c035_jmp", 5, 0, 0, 0);
      tick8("c035d");
      exp8("c035_jmp3f", 'h3F, 0, 0, 0);
      tick8("c035e");
      exp8("c035_wrap", 0, 0, 0, 0);

      // Random programs, inputs, enables and resets; the inactive core is kept in reset.
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 16; i++) prog4[i] = 8'($urandom);
         for (int i = 0; i < 64; i++) prog8[i] = 12'($urandom);
         rst8 = 1'b1;
         rst4 = 1'b1;
         tick4("rnd4");
         for (int c = 0; c < 150; c++) begin
            rst4 = ($urandom_range(0, 24) == 0);
            bus4.en = ($urandom_range(0, 3) != 0);
            bus4.in_port = 4'($urandom);
            tick4("rnd4");
         end
         rst4 = 1'b1;
         rst8 = 1'b1;
         tick8("rnd8");
         for (int c = 0; c < 150; c++) begin
            rst8 = ($urandom_range(0, 24) == 0);
            bus8.en = ($urandom_range(0, 3) != 0);
            bus8.in_port = 8'($urandom);
            tick8("rnd8");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/td4x_core.md
TD4X_CORE -- requirements
Module: td4x_core

Interface
REQ-001 Parameter DW, default 4: data width of registers A and B, the ALU, the immediate field and the ports; legal range 4..16.
REQ-002 Parameter AW, default 4: program-counter and instruction-address width; AW <= DW is required.
REQ-003 clk  input  1  clock; all state changes occur on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  execute enable; when low, the core holds all state (single-step/pause).
REQ-006 instr_addr  output  AW  program-memory address, equal to the PC.
REQ-007 instr_data  input  4+DW  instruction {op[3:0], im[DW-1:0]}, valid combinationally in the same cycle as instr_addr.
REQ-008 in_port  input  DW  general input port.
REQ-009 out_port  output  DW  registered output port.
REQ-010 carry  output  1  registered carry flag.
REQ-011 halted  output  1  high once HLT has executed.

Function
REQ-012 The core is single-cycle: each rising clk with en=1, rst=0 and halted=0 executes exactly one instruction and commits all its results.
REQ-013 Opcodes: 0000 ADD A,im; 0101 ADD B,im; 0011 MOV A,im; 0111 MOV B,im; 0001 MOV A,B; 0100 MOV B,A; 0010 IN A; 0110 IN B; 1001 OUT B; 1011 OUT im; 1111 JMP im; 1110 JNC im; 1010 JC im; 1000 HLT.
REQ-014 Every other opcode is a NOP: PC advances by 1, carry is cleared, and no other state changes.
REQ-015 ADD computes reg + im modulo 2^DW; carry takes bit DW of the (DW+1)-bit sum.
REQ-016 Every executed instruction other than ADD clears carry, including jumps, HLT and OUT.
REQ-017 JNC and JC test the carry value registered before the current instruction: JNC jumps when carry=0, JC jumps when carry=1.
REQ-018 Jump target is im[AW-1:0]; a jump not taken advances PC by 1.
REQ-019 Non-jump instructions advance PC by 1 modulo 2^AW; from the all-ones address the PC wraps to 0 without error.
REQ-020 OUT B loads out_port from B; OUT im loads out_port from im; out_port holds its value otherwise.
REQ-021 IN A and IN B sample in_port on the executing edge.
REQ-022 HLT sets halted=1 and leaves the PC on the HLT address; afterwards no state changes until rst.
REQ-023 With en=0, PC, A, B, out_port, carry and halted all hold; instr_addr stays stable.
REQ-024 rst takes priority over en and over halted.

Reset
REQ-025 On a clk edge with rst=1: PC=0, A=0, B=0, out_port=0, carry=0, halted=0.
REQ-026 Reset asserted mid-program discards the instruction in flight; the first instruction executes on the first edge with rst=0 and en=1.

Structure
REQ-027 Package td4x_pkg holds the 4-bit opcode constants and the decoded-control struct (destination select, source select, ALU-add flag, jump kind, out-load, halt).
REQ-028 Sub-module td4x_decode is combinational: it maps op and carry to the control struct. The core holds all state and the datapath.
REQ-029 No latches are allowed: every combinational path assigns a default, including unlisted opcodes.

Verification
REQ-030 DW=4: MOV A,0xF; ADD A,1 -> A=0, carry=1; the next JC 5 -> PC=5, carry=0.
REQ-031 ADD A,1 with A=3, then JNC 2 -> jump to 2; a following JNC re-evaluates against the cleared carry and jumps again.
REQ-032 MOV B,0xA; OUT B -> out_port=0xA; OUT 0x3 -> out_port=0x3; MOV A,B leaves out_port=0x3.
REQ-033 in_port=0x6; IN A; MOV B,A; OUT B -> out_port=0x6. Toggling en low between instructions -> no state change on gated edges.
REQ-034 HLT at address 7 -> halted=1, instr_addr=7 held for 10 cycles; rst -> all outputs 0, PC=0.
REQ-035 DW=8, AW=6: ADD A,0xFF with A=0x01 -> A=0x00, carry=1; JMP 0xC5 -> PC=0x05; NOP at 0x3F -> PC wraps to 0.
